// File: rtl/lru_arbiter_if.sv
// Request/grant bundle between the front-panel requesters and lru_arbiter.
// The master drives requests and the release strobe; the slave (arbiter) answers with grants.
interface lru_arbiter_if #(
   parameter int N = 5
);
   localparam int W = $clog2(N);

   logic [N-1:0] req;
   logic         done;
   logic [N-1:0] gnt;
   logic         busy;
   logic [W-1:0] lru_idx;
   logic         timeout;

   modport master (output req, done, input gnt, busy, lru_idx, timeout);
   modport slave  (input req, done, output gnt, busy, lru_idx, timeout);
endinterface

// File: rtl/lru_arbiter.sv
// Least-recently-used arbiter with a permutation rank table and a one-cycle gap between holders.
// Define LRU_ARB_TIMEOUT_EN to revoke grants held longer than HOLD_MAX prescaler ticks.
module lru_arbiter #(
   parameter int N        = 5,
   parameter int HOLD_MAX = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   lru_arbiter_if.slave bus
);
   localparam int W = $clog2(N);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t       state, state_nxt;
   logic [W-1:0] rank     [N];
   logic [W-1:0] rank_nxt [N];
   logic [N-1:0] gnt_q, gnt_nxt;
   logic [W-1:0] lru_q, lru_nxt;
   logic         timeout_q, timeout_nxt;
   logic         win_vld;
   logic [W-1:0] win_idx, win_rank;
   logic         to_hit;

   // Winner is the requester holding the highest rank; ranks are unique so no tie-break is needed.
   always_comb begin
      win_vld  = 1'b0;
      win_idx  = '0;
      win_rank = '0;
      for (int i = 0; i < N; i++) begin
         if (bus.req[i] && (!win_vld || rank[i] > win_rank)) begin
            win_vld  = 1'b1;
            win_idx  = W'(i);
            win_rank = rank[i];
         end
      end
   end

`ifdef LRU_ARB_TIMEOUT_EN
   logic [9:0] hold_cnt, hold_cnt_inc;

   assign hold_cnt_inc = (hold_cnt == 10'd1023) ? hold_cnt : hold_cnt + 10'd1;
   // Fires on the tick that brings the count to HOLD_MAX, so a grant spans at most HOLD_MAX ticks.
   assign to_hit       = tick && (hold_cnt_inc == 10'(HOLD_MAX));

   always_ff @(posedge clk) begin
      if (rst)                   hold_cnt <= '0;
      else if (state != GRANT)   hold_cnt <= '0;
      else if (tick)             hold_cnt <= hold_cnt_inc;
   end
`else
   logic       unused_tick;
   logic [9:0] unused_hold;

   assign unused_tick = tick;
   assign unused_hold = 10'(HOLD_MAX);
   assign to_hit      = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      gnt_nxt     = gnt_q;
      timeout_nxt = 1'b0;
      for (int j = 0; j < N; j++) rank_nxt[j] = rank[j];
      case (state)
         IDLE: begin
            if (win_vld) begin
               state_nxt = GRANT;
               gnt_nxt   = N'(1) << win_idx;
               for (int j = 0; j < N; j++) begin
                  if (W'(j) == win_idx)     rank_nxt[j] = '0;
                  else if (rank[j] < win_rank) rank_nxt[j] = rank[j] + W'(1);
               end
            end
         end
         GRANT: begin
            if (bus.done || !(|(bus.req & gnt_q)) || to_hit) begin
               state_nxt   = GAP;
               gnt_nxt     = '0;
               timeout_nxt = to_hit;
            end
         end
         GAP:     state_nxt = IDLE;
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      lru_nxt = '0;
      for (int j = 0; j < N; j++)
         if (rank_nxt[j] == W'(N - 1)) lru_nxt = W'(j);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         gnt_q     <= '0;
         lru_q     <= '0;
         timeout_q <= 1'b0;
         for (int j = 0; j < N; j++) rank[j] <= W'(N - 1 - j);
      end else begin
         state     <= state_nxt;
         gnt_q     <= gnt_nxt;
         lru_q     <= lru_nxt;
         timeout_q <= timeout_nxt;
         for (int j = 0; j < N; j++) rank[j] <= rank_nxt[j];
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.busy    = |gnt_q;
   assign bus.lru_idx = lru_q;
   assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_lru_arbiter.sv
// Directed bench for lru_arbiter: grant order, LRU priority, release timing, reset and hold limit.
module tb_lru_arbiter;
`ifdef LRU_ARB_TIMEOUT_EN
   localparam int HM = 3;
`else
   localparam int HM = 10;
`endif

   logic clk = 1'b0;
   logic rst;
   logic tick;
   int   ncmp = 0;
   int   nerr = 0;

   lru_arbiter_if #(.N(5)) bus ();

   lru_arbiter #(.N(5), .HOLD_MAX(HM)) dut (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // done pulse, then check the released cycle and the gap cycle
   task automatic release_done();
      bus.done = 1'b1;
      step();
      chk("rel_gnt", 32'(bus.gnt), 32'h0);
      chk("rel_busy", 32'(bus.busy), 32'h0);
      bus.done = 1'b0;
      step();
      chk("gap_gnt", 32'(bus.gnt), 32'h0);
   endtask

   task automatic expect_grant(input string tag, input logic [4:0] g, input logic [2:0] lru);
      step();
      chk({tag, "_gnt"}, 32'(bus.gnt), 32'(g));
      chk({tag, "_busy"}, 32'(bus.busy), 32'h1);
      chk({tag, "_lru"}, 32'(bus.lru_idx), 32'(lru));
   endtask

   initial begin
      rst      = 1'b1;
      tick     = 1'b0;
      bus.req  = '0;
      bus.done = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("rst_gnt", 32'(bus.gnt), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_lru", 32'(bus.lru_idx), 32'h0);
      chk("rst_to", 32'(bus.timeout), 32'h0);

      // round robin under full load
      bus.req = 5'b11111;
      expect_grant("rr0", 5'b00001, 3'd1);
      release_done();
      expect_grant("rr1", 5'b00010, 3'd2);
      release_done();
      expect_grant("rr2", 5'b00100, 3'd3);
      release_done();
      expect_grant("rr3", 5'b01000, 3'd4);
      release_done();
      expect_grant("rr4", 5'b10000, 3'd0);
      release_done();
      expect_grant("rr5", 5'b00001, 3'd1);
      release_done();
      bus.req = '0;
      step();

      // recency decides between 0 and 2
      do_reset();
      bus.req = 5'b00100;
      expect_grant("p2", 5'b00100, 3'd0);
      release_done();
      bus.req = 5'b00001;
      expect_grant("p0", 5'b00001, 3'd1);
      release_done();
      bus.req = 5'b00101;
      expect_grant("pa", 5'b00100, 3'd1);
      release_done();
      expect_grant("pb", 5'b00001, 3'd1);
      bus.req = '0;
      step();
      chk("drop_gnt", 32'(bus.gnt), 32'h0);
      step();
      // done outside GRANT has no effect
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      chk("idle_done", 32'(bus.gnt), 32'h0);

      // reset during a grant
      bus.req = 5'b01000;
      expect_grant("pre_rst", 5'b01000, 3'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
      chk("mid_rst_busy", 32'(bus.busy), 32'h0);
      chk("mid_rst_lru", 32'(bus.lru_idx), 32'h0);
      bus.req = 5'b11111;
      expect_grant("post_rst", 5'b00001, 3'd1);
      bus.req = '0;
      step();
      step();

`ifdef LRU_ARB_TIMEOUT_EN
      do_reset();
      bus.req = 5'b00010;
      expect_grant("to_g", 5'b00010, 3'd0);
      for (int t = 1; t <= 3; t++) begin
         for (int c = 0; c < 3; c++) begin
            step();
            chk("to_hold", 32'(bus.gnt), 32'h2);
            chk("to_quiet", 32'(bus.timeout), 32'h0);
         end
         tick = 1'b1;
         step();
         tick = 1'b0;
         if (t < 3) begin
            chk("to_tick_gnt", 32'(bus.gnt), 32'h2);
            chk("to_tick_to", 32'(bus.timeout), 32'h0);
         end else begin
            chk("to_fire_gnt", 32'(bus.gnt), 32'h0);
            chk("to_fire_to", 32'(bus.timeout), 32'h1);
         end
      end
      step();
      chk("to_pulse_end", 32'(bus.timeout), 32'h0);
      chk("to_gap_gnt", 32'(bus.gnt), 32'h0);
      expect_grant("to_regnt", 5'b00010, 3'd0);
      bus.req = '0;
      step();
`else
      do_reset();
      bus.req = 5'b01000;
      expect_grant("nt_g", 5'b01000, 3'd0);
      tick = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         step();
         chk("nt_hold", 32'(bus.gnt), 32'h8);
         chk("nt_to", 32'(bus.timeout), 32'h0);
      end
      tick = 1'b0;
      bus.req = '0;
      step();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule

// File: doc/lru_arbiter.md
# lru_arbiter

Least-recently-used arbiter that shares one resource among N requesters (button/LED front panel, downstream single-user datapath). Keeps a recency ranking of all requesters, grants the requesting one that was served longest ago, holds the grant until release, and optionally revokes grants held too long, measured in prescaler ticks. Sits between the button synchronizers/debouncers and the shared resource; `lru_idx` drives the panel LEDs.

## Interface
- `N`, 5: number of requesters, 2..8.
- `HOLD_MAX`, 10: maximum grant length in `tick` pulses. Used only with the timeout feature, 1..1023.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle enable pulse from the shared prescaler.
- `req`  in  N  per-requester request level.
- `done`  in  1  holder's release strobe, one cycle.
- `gnt`  out  N  one-hot grant, registered.
- `busy`  out  1  a grant is active (OR of `gnt`).
- `lru_idx`  out  $clog2(N)  index currently ranked least recently used.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- Rank registers: `rank[i]`, $clog2(N) bits each. The ranks always form a permutation of 0..N-1. Rank 0 is most recently granted; rank N-1 is least recently used.
- Reset values:
  - `rank[i] = N-1-i`, so requester 0 is LRU.
  - `gnt = 0`, `busy = 0`, `timeout = 0`, `lru_idx = 0`.
  - State IDLE; hold counter 0.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If `req != 0`, the winner k is the requester with `req[k]=1` and the highest rank. Ranks are unique, so there is never a tie.
  - Go to GRANT, set `gnt = 1<<k`, clear the hold counter.
  - Rank update in the same cycle: `rank[k] <= 0`; every j with `rank[j] < rank[k]` increments; all others are unchanged.
- GRANT:
  - Leave on `done`, on `req[k]` deasserting, or on timeout.
  - On exit: clear `gnt` and go to GAP.
  - The `done` input is ignored in IDLE and GAP.
- GAP: exactly one cycle with no grant, then IDLE. This guarantees the resource sees a deassertion between holders.
- Hold counter:
  - 10 bits; increments on `tick` only while in GRANT; saturates at 1023.
  - Timeout occurs when the counter equals `HOLD_MAX` and `tick` is high. Exit GRANT and pulse `timeout` in the same registered update as the `gnt` clear.
- Simultaneous events: if `done`, `req[k]` drop and timeout coincide, release happens once and `timeout` still pulses. Release does not change rank, because rank was updated at grant time.
- `lru_idx`: registered; it is the index with `rank = N-1` after any rank update.
- `rst` mid-grant: next edge restores all reset values; `gnt` drops without a GAP cycle.

## Timing
- Grant latency: `req` high in IDLE at edge t gives `gnt` at edge t+1.
- Release: `done` sampled at edge t gives `gnt = 0` at t+1. Earliest next grant is at t+3 (GAP at t+1..t+2, IDLE arbitrates at t+2).
- `busy` and `lru_idx` are registered and update on the same edge as `gnt`/`rank`.
- Timeout: the grant lasts at most `HOLD_MAX` tick pulses after being issued. `timeout` is high for exactly one cycle.

## Configuration
- `LRU_ARB_TIMEOUT_EN`:
  - Defined: hold counter, `HOLD_MAX` check and `timeout` pulse are implemented.
  - Undefined: no hold counter is synthesized, `timeout` is tied 0, `tick` is unused, and a grant ends only on `done` or `req` drop.

## Test plan
- Reset, then `req=5'b11111` held with `done` pulsed each grant: grant order is 0,1,2,3,4,0. `lru_idx` after the first grant is 1.
- Grant 2, then 0, then `req=5'b00101`: requester 2 wins (rank 1 vs 0). Next cycle after release, with `req=5'b00101` still set, requester 0 wins.
- `done` at edge t: `gnt = 0` at t+1, `busy = 0` at t+1, and no `gnt` bit at t+2.
- Timeout feature defined, `HOLD_MAX=3`, `tick` every 4 cycles, `req[1]` held with no `done`: `timeout` pulses once on the third tick edge and `gnt[1]` drops on the same edge. After the GAP, requester 1 is re-granted only if it is the sole requester.
- `rst` asserted while `gnt=5'b01000`: next edge `gnt = 0`, `rank = {0,1,2,3,4}` for i=4..0, `lru_idx = 0`.
- Timeout feature undefined, `req[3]` held for 2000 ticks: `gnt[3]` stays high and `timeout` stays 0 throughout.
